dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 32×32 data memory between the pipeline MEM stage (port C) and the debug/loader port (port D). It sits between both requesters and the memory:
- latches one request at a time;
- drives the memory's write enable, address and write data for exactly one cycle;
- returns registered read data with a one-cycle acknowledge.

Priority alternates round-robin so neither port starves.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_pick2.sv | 24 ++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port ids
// and default geometry of the 32x32 data memory.
package dmem_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester round-robin pick: on a tie the port that was not served
// last wins, otherwise the sole requester wins.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic req_c,
    input  logic req_d,
    input  logic last,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = req_c | req_d;
        if (req_c && req_d) begin
            grant_port = ~last;
        end else if (req_d) begin
            grant_port = PORT_D;
        end else begin
            grant_port = PORT_C;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one data memory between the MEM stage (port C)
// and the debug/loader port (port D); one transaction in flight at a time.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_datain,
    output logic [DW-1:0] c_dataout,
    output logic          c_ack,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_datain,
    output logic [DW-1:0] d_dataout,
    output logic          d_ack,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          sel_port_q, sel_port_d;
    logic          sel_we_q, sel_we_d;
    logic [AW-1:0] sel_addr_q, sel_addr_d;
    logic [DW-1:0] sel_datain_q, sel_datain_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic grant_valid;
    logic grant_port;

    rr_pick2 u_pick (
        .req_c       (c_req),
        .req_d       (d_req),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sel_port_d   = sel_port_q;
        sel_we_d     = sel_we_q;
        sel_addr_d   = sel_addr_q;
        sel_datain_d = sel_datain_q;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    sel_port_d = grant_port;
                    if (grant_port == PORT_D) begin
                        sel_we_d     = d_we;
                        sel_addr_d   = d_addr;
                        sel_datain_d = d_datain;
                    end else begin
                        sel_we_d     = c_we;
                        sel_addr_d   = c_addr;
                        sel_datain_d = c_datain;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Read data is captured even on writes (pre-write word); requester ignores it.
                rdata_d = mem_dataout;
                last_d  = sel_port_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= PORT_D;
            sel_port_q   <= PORT_C;
            sel_we_q     <= 1'b0;
            sel_addr_q   <= '0;
            sel_datain_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sel_port_q   <= sel_port_d;
            sel_we_q     <= sel_we_d;
            sel_addr_q   <= sel_addr_d;
            sel_datain_q <= sel_datain_d;
            rdata_q      <= rdata_d;
        end
    end

    // Reset gates the strobe directly so a reset landing in ACCESS cannot write.
    assign mem_we     = (state_q == ACCESS) & sel_we_q & ~rst;
    assign mem_addr   = sel_addr_q;
    assign mem_datain = sel_datain_q;

    assign c_ack     = (state_q == DONE) && (sel_port_q == PORT_C);
    assign d_ack     = (state_q == DONE) && (sel_port_q == PORT_D);
    assign c_dataout = c_ack ? rdata_q : '0;
    assign d_dataout = d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural 32x32 memory, a
// vector table of single-port transactions and scoreboarded corner cases.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [4:0]  c_addr, d_addr;
    logic [31:0] c_datain, d_datain, c_dataout, d_dataout;
    logic        c_ack, d_ack;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[8];

    logic [31:0] mem [32];
    bit loaded = 1'b0;

    dmem_arbiter #(.AW(5), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .c_req       (c_req),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_datain    (c_datain),
        .c_dataout   (c_dataout),
        .c_ack       (c_ack),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_datain    (d_datain),
        .d_dataout   (d_dataout),
        .d_ack       (d_ack),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory preloaded with word i = i + 9 (word 1 = 0xa, word 4 = 0xd).
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i + 9);
            loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_datain;
        end
    end
    assign mem_dataout = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and retire any ack against the scoreboard.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (c_ack || d_ack) begin
            chk("ack_exclusive", {31'd0, c_ack & d_ack}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {31'd0, d_ack}, 32'hffff_ffff);
            end else begin
                e = sb_q.pop_front();
                chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                chk("ack_data", d_ack ? d_dataout : c_dataout, e.data);
                chk("other_dataout", d_ack ? c_dataout : d_dataout, 32'd0);
            end
        end
    endtask

    task automatic drop_all();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_datain = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_datain = '0;
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit hold);
        int n, wec;
        bit got;
        logic [4:0] wa;
        sb_q.push_back('{port: port, data: exp_rd});
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_datain = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_datain = wdata;
        end
        n = 0; wec = 0; got = 1'b0; wa = '0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (mem_we) begin
                wec++;
                wa = mem_addr;
            end
            if (port ? d_ack : c_ack) got = 1'b1;
            if (!hold && n == 1) drop_all();
        end
        drop_all();
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (!got) sb_q.delete();
        chk("ack_latency", n, 32'd2);
        chk("we_pulses", wec, we ? 32'd1 : 32'd0);
        if (we) chk("we_addr", {27'd0, wa}, {27'd0, addr});
        tick();
    endtask

    initial begin
        int cnt, n, prev;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 5'd1,  wdata: 32'h0,          exp_rd: 32'h0000000a};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 5'd7,  wdata: 32'h12345678,   exp_rd: 32'h00000010};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 5'd7,  wdata: 32'h0,          exp_rd: 32'h12345678};
        vecs[3] = '{port: 1'b1, we: 1'b0, addr: 5'd31, wdata: 32'h0,          exp_rd: 32'h00000028};
        vecs[4] = '{port: 1'b0, we: 1'b1, addr: 5'd0,  wdata: 32'ha5a5a5a5,   exp_rd: 32'h00000009};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 5'd0,  wdata: 32'h0,          exp_rd: 32'ha5a5a5a5};
        vecs[6] = '{port: 1'b0, we: 1'b1, addr: 5'd31, wdata: 32'hffffffff,   exp_rd: 32'h00000028};
        vecs[7] = '{port: 1'b0, we: 1'b0, addr: 5'd31, wdata: 32'h0,          exp_rd: 32'hffffffff};

        rst = 1'b1;
        drop_all();

        // Reset: two cycles with everything idle.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_outputs", {c_ack, d_ack, mem_we}, 32'd0);
            chk("reset_dataout", c_dataout | d_dataout, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("idle_outputs", {c_ack, d_ack, mem_we}, 32'd0);

        // Single-port transactions from the table.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b1);
        end

        // Contention from reset release: C, D, C, D, 3 cycles apart.
        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{port: 1'b0, data: 32'h0000000b});
            sb_q.push_back('{port: 1'b1, data: 32'h0000000e});
        end
        tick();
        tick();
        rst = 1'b0;
        cnt = 0; n = 0; prev = 0;
        while (cnt < 4 && n < 40) begin
            tick();
            n++;
            if (c_ack || d_ack) begin
                cnt++;
                if (cnt > 1) chk("ack_gap", cyc - prev, 32'd3);
                prev = cyc;
                if (cnt == 4) drop_all();
            end
        end
        drop_all();
        chk("contention_acks", cnt, 32'd4);
        if (cnt < 4) sb_q.delete();
        tick();

        // Withdrawal: req dropped in ACCESS, write still lands and acks.
        do_txn(1'b0, 1'b1, 5'd3, 32'hdeadbeef, 32'h0000000c, 1'b0);
        do_txn(1'b1, 1'b0, 5'd3, 32'h0, 32'hdeadbeef, 1'b1);

        // Reset during the ACCESS cycle of a D write to addr 4.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd4; d_datain = 32'hffffffff;
        tick();
        rst = 1'b1;
        drop_all();
        #1;
        chk("rst_access_we", {31'd0, mem_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_ack", {c_ack, d_ack}, 32'd0);
            rst = 1'b0;
        end

        // First tie after reset goes to C; addr 4 keeps its preload.
        sb_q.push_back('{port: 1'b0, data: 32'h0000000d});
        sb_q.push_back('{port: 1'b1, data: 32'h0000000d});
        c_req = 1'b1; c_addr = 5'd4;
        d_req = 1'b1; d_addr = 5'd4;
        cnt = 0; n = 0;
        while (cnt < 2 && n < 20) begin
            tick();
            n++;
            if (c_ack || d_ack) begin
                cnt++;
                if (cnt == 2) drop_all();
            end
        end
        drop_all();
        chk("tie_acks", cnt, 32'd2);
        tick();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
